// File: rtl/tuner_phy_pkg.sv
// Shared types for the tuner sequencer: FSM state encoding, error codes and
// the helper that identifies which states are covered by the watchdog.
package tuner_phy_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SEARCH_REQ  = 3'd1,
        SEARCH_WAIT = 3'd2,
        SELECT      = 3'd3,
        LOCK_REQ    = 3'd4,
        LOCKED      = 3'd5,
        RELOCK      = 3'd6,
        FAIL        = 3'd7
    } tuner_seq_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_NO_PEAKS = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_BAD_IDX  = 2'd3
    } tuner_seq_err_e;

    // States that wait on tuner_phy; LOCKED may legitimately idle forever.
    function automatic logic seq_is_watched(input tuner_seq_state_e s);
        return (s == SEARCH_REQ) || (s == SEARCH_WAIT) || (s == LOCK_REQ) || (s == RELOCK);
    endfunction

endpackage

// File: rtl/tuner_peak_select.sv
// Picks the target peak: sequential argmax over entries 0..cnt-1 (one per
// cycle, lowest index wins ties) or a one-cycle fixed-index lookup.
module tuner_peak_select #(
    parameter int  DAC_WIDTH  = 8,
    parameter int  ADC_WIDTH  = 8,
    parameter int  NUM_TARGET = 8,
    localparam int IDX_W      = $clog2(NUM_TARGET),
    localparam int CNT_W      = IDX_W + 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_start,
    input  logic                                 i_mode,
    input  logic [IDX_W-1:0]                     i_fix_idx,
    input  logic [CNT_W-1:0]                     i_cnt,
    input  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] i_pwr,
    input  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] i_tune,
    output logic                                 o_done,
    output logic                                 o_bad_idx,
    output logic [IDX_W-1:0]                     o_idx,
    output logic [ADC_WIDTH-1:0]                 o_pwr,
    output logic [DAC_WIDTH-1:0]                 o_tune
);

    logic                 r_busy;
    logic                 r_mode;
    logic [IDX_W-1:0]     r_fix_idx;
    logic [IDX_W-1:0]     r_scan;
    logic [IDX_W-1:0]     r_best_idx;
    logic [ADC_WIDTH-1:0] r_best_pwr;

    logic                 w_last;
    logic                 w_take;
    logic [IDX_W-1:0]     w_idx;

    assign w_last    = ({1'b0, r_scan} == (i_cnt - CNT_W'(1)));
    assign w_take    = (i_pwr[r_scan] > r_best_pwr);
    assign o_done    = r_busy & (r_mode | w_last);
    assign o_bad_idx = r_mode & ({1'b0, r_fix_idx} >= i_cnt);

    // The final compare is folded in combinationally so the result is ready
    // on the same edge that retires the last entry.
    assign w_idx  = r_mode ? r_fix_idx : (w_take ? r_scan : r_best_idx);
    assign o_idx  = w_idx;
    assign o_pwr  = i_pwr[w_idx];
    assign o_tune = i_tune[w_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy     <= 1'b0;
            r_mode     <= 1'b0;
            r_fix_idx  <= '0;
            r_scan     <= '0;
            r_best_idx <= '0;
            r_best_pwr <= '0;
        end else if (i_start) begin
            r_busy     <= 1'b1;
            r_mode     <= i_mode;
            r_fix_idx  <= i_fix_idx;
            r_scan     <= '0;
            r_best_idx <= '0;
            r_best_pwr <= '0;
        end else if (r_busy) begin
            if (o_done) begin
                r_busy <= 1'b0;
            end else begin
                r_scan <= r_scan + IDX_W'(1);
                if (w_take) begin
                    r_best_idx <= r_scan;
                    r_best_pwr <= i_pwr[r_scan];
                end
            end
        end
    end

endmodule

// File: rtl/tuner_lock_seq.sv
// Search/select/lock sequencer driving tuner_phy for one microring, with
// bounded lock-resume retries, zero-peak retries and a wait-state watchdog.
module tuner_lock_seq
    import tuner_phy_pkg::*;
#(
    parameter int  DAC_WIDTH        = 8,
    parameter int  ADC_WIDTH        = 8,
    parameter int  NUM_TARGET       = 8,
    parameter int  MAX_RELOCK       = 3,
    parameter int  MAX_SEARCH_RETRY = 2,
    parameter int  TIMEOUT_CYCLES   = 4096,
    localparam int IDX_W            = $clog2(NUM_TARGET),
    localparam int CNT_W            = IDX_W + 1,
    localparam int RLK_W            = $clog2(MAX_RELOCK + 1)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_en,
    input  logic                                 i_cfg_sel_mode,
    input  logic [IDX_W-1:0]                     i_cfg_sel_idx,
    output logic                                 o_search_trig_val,
    input  logic                                 i_search_trig_rdy,
    input  logic                                 i_search_peaks_val,
    output logic                                 o_search_peaks_rdy,
    input  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] i_ring_tune_peaks,
    input  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] i_pwr_peaks,
    input  logic [CNT_W-1:0]                     i_peaks_cnt,
    output logic                                 o_lock_trig_val,
    input  logic                                 i_lock_trig_rdy,
    input  logic                                 i_lock_intr_val,
    output logic                                 o_lock_intr_rdy,
    output logic                                 o_lock_resume_val,
    input  logic                                 i_lock_resume_rdy,
    output logic [ADC_WIDTH-1:0]                 o_cfg_pwr_peak,
    output logic [DAC_WIDTH-1:0]                 o_cfg_ring_tune_peak,
    output logic [IDX_W-1:0]                     o_sel_idx,
    output logic                                 o_locked,
    output logic                                 o_err,
    output logic [1:0]                           o_err_code,
    output logic [RLK_W-1:0]                     o_relock_cnt,
    output tuner_seq_state_e                     o_state
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_SEARCH_RETRY + 2);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    tuner_seq_state_e r_state;
    tuner_seq_err_e   r_err_code;
    logic             r_search_trig_val;
    logic             r_search_peaks_rdy;
    logic             r_lock_trig_val;
    logic             r_lock_intr_rdy;
    logic             r_lock_resume_val;
    logic             r_locked;
    logic             r_err;
    logic [ADC_WIDTH-1:0] r_cfg_pwr;
    logic [DAC_WIDTH-1:0] r_cfg_tune;
    logic [IDX_W-1:0]     r_sel_idx;
    logic [RLK_W-1:0]     r_relock_cnt;
    logic [RTY_W-1:0]     r_search_retry;
    logic [WD_W-1:0]      r_wdog;
    logic [CNT_W-1:0]     r_peaks_cnt;
    logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] r_pwr_tbl;
    logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] r_tune_tbl;

    tuner_seq_state_e     w_state_next;
    logic                 w_trig_xfer;
    logic                 w_peaks_xfer;
    logic                 w_peaks_zero;
    logic                 w_lock_xfer;
    logic                 w_intr_xfer;
    logic                 w_resume_xfer;
    logic                 w_wdog_expire;
    logic [RTY_W-1:0]     w_retry_inc;
    logic                 w_sel_start;
    logic                 w_sel_done;
    logic                 w_sel_bad;
    logic [IDX_W-1:0]     w_sel_idx;
    logic [ADC_WIDTH-1:0] w_sel_pwr;
    logic [DAC_WIDTH-1:0] w_sel_tune;

    assign w_trig_xfer   = r_search_trig_val & i_search_trig_rdy;
    assign w_peaks_xfer  = i_search_peaks_val & r_search_peaks_rdy;
    assign w_peaks_zero  = (i_peaks_cnt == '0);
    assign w_lock_xfer   = r_lock_trig_val & i_lock_trig_rdy;
    assign w_intr_xfer   = i_lock_intr_val & r_lock_intr_rdy;
    assign w_resume_xfer = r_lock_resume_val & i_lock_resume_rdy;
    assign w_wdog_expire = seq_is_watched(r_state) && (r_wdog == WD_LAST);
    assign w_retry_inc   = r_search_retry + RTY_W'(1);
    assign w_sel_start   = w_peaks_xfer & ~w_peaks_zero;

    tuner_peak_select #(
        .DAC_WIDTH  (DAC_WIDTH),
        .ADC_WIDTH  (ADC_WIDTH),
        .NUM_TARGET (NUM_TARGET)
    ) u_peak_select (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (w_sel_start),
        .i_mode    (i_cfg_sel_mode),
        .i_fix_idx (i_cfg_sel_idx),
        .i_cnt     (r_peaks_cnt),
        .i_pwr     (r_pwr_tbl),
        .i_tune    (r_tune_tbl),
        .o_done    (w_sel_done),
        .o_bad_idx (w_sel_bad),
        .o_idx     (w_sel_idx),
        .o_pwr     (w_sel_pwr),
        .o_tune    (w_sel_tune)
    );

    // A completed handshake is always checked before the watchdog, so a
    // transfer landing on the expiry cycle is honoured.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:        if (i_en) w_state_next = SEARCH_REQ;
            SEARCH_REQ:  if (w_trig_xfer)        w_state_next = SEARCH_WAIT;
                         else if (w_wdog_expire) w_state_next = FAIL;
            SEARCH_WAIT: if (w_peaks_xfer) begin
                             if (!w_peaks_zero)
                                 w_state_next = SELECT;
                             else if (w_retry_inc > RTY_W'(MAX_SEARCH_RETRY))
                                 w_state_next = FAIL;
                             else
                                 w_state_next = SEARCH_REQ;
                         end else if (w_wdog_expire) begin
                             w_state_next = FAIL;
                         end
            SELECT:      if (w_sel_done) w_state_next = w_sel_bad ? FAIL : LOCK_REQ;
            LOCK_REQ:    if (w_lock_xfer)        w_state_next = LOCKED;
                         else if (w_wdog_expire) w_state_next = FAIL;
            LOCKED:      if (w_intr_xfer)
                             w_state_next = (r_relock_cnt < RLK_W'(MAX_RELOCK)) ? RELOCK : SEARCH_REQ;
            RELOCK:      if (w_resume_xfer)      w_state_next = LOCKED;
                         else if (w_wdog_expire) w_state_next = FAIL;
            FAIL:        if (!i_en) w_state_next = IDLE;
            default:     w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state            <= IDLE;
            r_err_code         <= ERR_NONE;
            r_search_trig_val  <= 1'b0;
            r_search_peaks_rdy <= 1'b0;
            r_lock_trig_val    <= 1'b0;
            r_lock_intr_rdy    <= 1'b0;
            r_lock_resume_val  <= 1'b0;
            r_locked           <= 1'b0;
            r_err              <= 1'b0;
            r_cfg_pwr          <= '0;
            r_cfg_tune         <= '0;
            r_sel_idx          <= '0;
            r_relock_cnt       <= '0;
            r_search_retry     <= '0;
            r_wdog             <= '0;
            r_peaks_cnt        <= '0;
            r_pwr_tbl          <= '0;
            r_tune_tbl         <= '0;
        end else begin
            r_state            <= w_state_next;
            r_search_trig_val  <= (w_state_next == SEARCH_REQ);
            r_search_peaks_rdy <= (w_state_next == SEARCH_WAIT);
            r_lock_trig_val    <= (w_state_next == LOCK_REQ);
            r_lock_intr_rdy    <= (w_state_next == LOCKED);
            r_lock_resume_val  <= (w_state_next == RELOCK);
            r_locked           <= (w_state_next == LOCKED);
            r_err              <= (w_state_next == FAIL);

            if ((w_state_next != r_state) || !seq_is_watched(r_state))
                r_wdog <= '0;
            else
                r_wdog <= r_wdog + WD_W'(1);

            if (w_peaks_xfer) begin
                r_peaks_cnt    <= i_peaks_cnt;
                r_pwr_tbl      <= i_pwr_peaks;
                r_tune_tbl     <= i_ring_tune_peaks;
                r_search_retry <= w_peaks_zero ? w_retry_inc : '0;
            end else if ((w_state_next == IDLE) ||
                         ((r_state == LOCKED) && (w_state_next == SEARCH_REQ))) begin
                r_search_retry <= '0;
            end

            if (w_lock_xfer)
                r_relock_cnt <= '0;
            else if (w_intr_xfer && (w_state_next == RELOCK))
                r_relock_cnt <= r_relock_cnt + RLK_W'(1);

            if (w_sel_done && !w_sel_bad) begin
                r_cfg_pwr  <= w_sel_pwr;
                r_cfg_tune <= w_sel_tune;
                r_sel_idx  <= w_sel_idx;
            end

            if ((r_state != FAIL) && (w_state_next == FAIL))
                r_err_code <= w_peaks_xfer ? ERR_NO_PEAKS :
                              ((r_state == SELECT) ? ERR_BAD_IDX : ERR_TIMEOUT);
            else if ((r_state == FAIL) && (w_state_next == IDLE))
                r_err_code <= ERR_NONE;
        end
    end

    assign o_state              = r_state;
    assign o_err_code           = r_err_code;
    assign o_search_trig_val    = r_search_trig_val;
    assign o_search_peaks_rdy   = r_search_peaks_rdy;
    assign o_lock_trig_val      = r_lock_trig_val;
    assign o_lock_intr_rdy      = r_lock_intr_rdy;
    assign o_lock_resume_val    = r_lock_resume_val;
    assign o_locked             = r_locked;
    assign o_err                = r_err;
    assign o_cfg_pwr_peak       = r_cfg_pwr;
    assign o_cfg_ring_tune_peak = r_cfg_tune;
    assign o_sel_idx            = r_sel_idx;
    assign o_relock_cnt         = r_relock_cnt;

endmodule

// File: tb/tb_tuner_lock_seq.sv
// Scoreboard bench for tuner_lock_seq: directed peer stimulus pushes expected
// handshake/error events; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_tuner_lock_seq;
    import tuner_phy_pkg::*;

    localparam int NT = 8;
    localparam int EV_SEARCH = 0;
    localparam int EV_LOCK   = 1;
    localparam int EV_RESUME = 2;
    localparam int EV_ERR    = 3;

    logic                 i_clk;
    logic                 i_rst_n;
    logic                 i_en;
    logic                 i_cfg_sel_mode;
    logic [2:0]           i_cfg_sel_idx;
    logic                 o_search_trig_val;
    logic                 i_search_trig_rdy;
    logic                 i_search_peaks_val;
    logic                 o_search_peaks_rdy;
    logic [NT-1:0][7:0]   i_ring_tune_peaks;
    logic [NT-1:0][7:0]   i_pwr_peaks;
    logic [3:0]           i_peaks_cnt;
    logic                 o_lock_trig_val;
    logic                 i_lock_trig_rdy;
    logic                 i_lock_intr_val;
    logic                 o_lock_intr_rdy;
    logic                 o_lock_resume_val;
    logic                 i_lock_resume_rdy;
    logic [7:0]           o_cfg_pwr_peak;
    logic [7:0]           o_cfg_ring_tune_peak;
    logic [2:0]           o_sel_idx;
    logic                 o_locked;
    logic                 o_err;
    logic [1:0]           o_err_code;
    logic [1:0]           o_relock_cnt;
    tuner_seq_state_e     o_state;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
    } ev_t;

    ev_t  q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   pw[8];
    logic prev_err = 1'b0;

    tuner_lock_seq #(
        .DAC_WIDTH(8), .ADC_WIDTH(8), .NUM_TARGET(NT),
        .MAX_RELOCK(3), .MAX_SEARCH_RETRY(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
        .i_cfg_sel_mode(i_cfg_sel_mode), .i_cfg_sel_idx(i_cfg_sel_idx),
        .o_search_trig_val(o_search_trig_val), .i_search_trig_rdy(i_search_trig_rdy),
        .i_search_peaks_val(i_search_peaks_val), .o_search_peaks_rdy(o_search_peaks_rdy),
        .i_ring_tune_peaks(i_ring_tune_peaks), .i_pwr_peaks(i_pwr_peaks), .i_peaks_cnt(i_peaks_cnt),
        .o_lock_trig_val(o_lock_trig_val), .i_lock_trig_rdy(i_lock_trig_rdy),
        .i_lock_intr_val(i_lock_intr_val), .o_lock_intr_rdy(o_lock_intr_rdy),
        .o_lock_resume_val(o_lock_resume_val), .i_lock_resume_rdy(i_lock_resume_rdy),
        .o_cfg_pwr_peak(o_cfg_pwr_peak), .o_cfg_ring_tune_peak(o_cfg_ring_tune_peak),
        .o_sel_idx(o_sel_idx), .o_locked(o_locked), .o_err(o_err), .o_err_code(o_err_code),
        .o_relock_cnt(o_relock_cnt), .o_state(o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic string kname(input int k);
        case (k)
            EV_SEARCH: return "search";
            EV_LOCK:   return "lock";
            EV_RESUME: return "resume";
            default:   return "err";
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic push(input int kind, input int a, input int b, input int c);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c;
        q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int a, input int b, input int c);
        ev_t e;
        $display("[%0t] %s a=%0d b=%0d c=%0d", $time, kname(kind), a, b, c);
        if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: got %s event, required none", kname(kind));
        end else begin
            e = q.pop_front();
            chk("sb_kind", kind, e.kind);
            if (kind == e.kind && kind != EV_SEARCH) begin
                chk({"sb_", kname(kind), "_a"}, a, e.a);
                if (kind == EV_LOCK) begin
                    chk("sb_lock_pwr", b, e.b);
                    chk("sb_lock_tune", c, e.c);
                end
            end
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_err <= 1'b0;
        end else begin
            if (o_search_trig_val && i_search_trig_rdy) check_ev(EV_SEARCH, 0, 0, 0);
            if (o_lock_trig_val && i_lock_trig_rdy)
                check_ev(EV_LOCK, int'(o_sel_idx), int'(o_cfg_pwr_peak), int'(o_cfg_ring_tune_peak));
            if (o_lock_resume_val && i_lock_resume_rdy) check_ev(EV_RESUME, int'(o_relock_cnt), 0, 0);
            if (o_err && !prev_err) check_ev(EV_ERR, int'(o_err_code), 0, 0);
            prev_err <= o_err;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return o_search_peaks_rdy;
            1:       return o_lock_intr_rdy;
            2:       return o_search_trig_val;
            3:       return o_lock_trig_val;
            4:       return o_err;
            default: return o_locked;
        endcase
    endfunction

    task automatic wait_sig(input int w, input string name, input int budget);
        int n = 0;
        while (!sig(w) && n < budget) begin
            tick();
            n++;
        end
        if (!sig(w)) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_%s: still low after %0d cycles, required high", name, budget);
        end
    endtask

    task automatic feed_peaks(input int cnt, input int tbase);
        wait_sig(0, "peaks_rdy", 64);
        for (int i = 0; i < NT; i++) begin
            i_pwr_peaks[i]       = 8'(pw[i]);
            i_ring_tune_peaks[i] = 8'(tbase + i);
        end
        i_peaks_cnt        = 4'(cnt);
        i_search_peaks_val = 1'b1;
        tick();
        i_search_peaks_val = 1'b0;
    endtask

    task automatic fire_intr();
        wait_sig(1, "intr_rdy", 64);
        i_lock_intr_val = 1'b1;
        tick();
        i_lock_intr_val = 1'b0;
    endtask

    function automatic int all_outs();
        return int'({o_search_trig_val, o_search_peaks_rdy, o_lock_trig_val, o_lock_intr_rdy,
                     o_lock_resume_val, o_cfg_pwr_peak, o_cfg_ring_tune_peak, o_sel_idx,
                     o_locked, o_err, o_err_code, o_relock_cnt});
    endfunction

    task automatic relock_then_research();
        for (int k = 1; k <= 3; k++) push(EV_RESUME, k, 0, 0);
        push(EV_SEARCH, 0, 0, 0);
        for (int k = 0; k < 4; k++) fire_intr();
        chk("research_trig_val", int'(o_search_trig_val), 1);
        chk("research_unlocked", int'(o_locked), 0);
    endtask

    initial begin
        int n;
        i_rst_n = 1'b0; i_en = 1'b0; i_cfg_sel_mode = 1'b0; i_cfg_sel_idx = '0;
        i_search_trig_rdy = 1'b1; i_search_peaks_val = 1'b0; i_ring_tune_peaks = '0;
        i_pwr_peaks = '0; i_peaks_cnt = '0; i_lock_trig_rdy = 1'b1; i_lock_intr_val = 1'b0;
        i_lock_resume_rdy = 1'b1;
        repeat (3) tick();
        chk("reset_state", int'(o_state), int'(IDLE));
        chk("reset_outputs", all_outs(), 0);
        i_rst_n = 1'b1;
        tick();

        // Max mode, ties keep lowest index, entry beyond cnt ignored.
        push(EV_SEARCH, 0, 0, 0);
        push(EV_LOCK, 1, 90, 8'h21);
        i_en = 1'b1;
        pw = '{40, 90, 90, 200, 0, 0, 0, 0};
        feed_peaks(3, 8'h20);
        n = 0;
        while (!o_lock_trig_val && n < 10) begin tick(); n++; end
        chk("lock_latency", n, 3);
        tick();
        chk("locked_after_trig", int'(o_locked), 1);

        relock_then_research();

        // Full table, max power shared by indices 1, 2 and 5.
        push(EV_LOCK, 1, 60, 8'h41);
        pw = '{12, 60, 60, 7, 59, 60, 3, 8};
        feed_peaks(8, 8'h40);
        wait_sig(5, "locked", 20);

        relock_then_research();

        // Fixed index beyond the peak count.
        push(EV_ERR, 3, 0, 0);
        i_cfg_sel_mode = 1'b1; i_cfg_sel_idx = 3'd5;
        pw = '{11, 22, 33, 44, 55, 66, 77, 88};
        feed_peaks(3, 8'h50);
        wait_sig(4, "err", 8);
        chk("bad_idx_code", int'(o_err_code), 3);
        chk("fail_cfg_pwr_hold", int'(o_cfg_pwr_peak), 60);
        chk("fail_cfg_tune_hold", int'(o_cfg_ring_tune_peak), 8'h41);
        chk("fail_sel_idx_hold", int'(o_sel_idx), 1);
        chk("fail_hs_quiet", int'({o_search_trig_val, o_search_peaks_rdy, o_lock_trig_val,
                                   o_lock_intr_rdy, o_lock_resume_val}), 0);
        i_en = 1'b0;
        tick();
        chk("fail_exit_state", int'(o_state), int'(IDLE));
        chk("fail_exit_code", int'(o_err_code), 0);
        chk("fail_exit_err", int'(o_err), 0);

        // Fixed index at cnt-1, then async reset while a resume is pending.
        push(EV_SEARCH, 0, 0, 0);
        push(EV_LOCK, 3, 40, 8'h63);
        i_cfg_sel_idx = 3'd3;
        i_en = 1'b1;
        pw = '{10, 20, 30, 40, 99, 99, 99, 99};
        feed_peaks(4, 8'h60);
        wait_sig(5, "locked", 20);
        i_lock_resume_rdy = 1'b0;
        fire_intr();
        repeat (3) tick();
        chk("resume_val_held", int'(o_lock_resume_val), 1);
        #3;
        i_rst_n = 1'b0;
        i_en = 1'b0;
        #1;
        chk("async_rst_resume_val", int'(o_lock_resume_val), 0);
        chk("async_rst_state", int'(o_state), int'(IDLE));
        chk("async_rst_outputs", all_outs(), 0);
        repeat (2) tick();
        i_rst_n = 1'b1;
        i_lock_resume_rdy = 1'b1;
        i_cfg_sel_mode = 1'b0;
        tick();

        // Three empty searches in a row.
        for (int k = 0; k < 3; k++) push(EV_SEARCH, 0, 0, 0);
        push(EV_ERR, 1, 0, 0);
        i_en = 1'b1;
        pw = '{0, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 3; k++) feed_peaks(0, 0);
        wait_sig(4, "err", 8);
        i_en = 1'b0;
        tick();

        // Watchdog expiry with trigger never accepted.
        push(EV_ERR, 2, 0, 0);
        i_search_trig_rdy = 1'b0;
        i_en = 1'b1;
        wait_sig(2, "trig_val", 8);
        n = 0;
        while (o_search_trig_val && n < 40) begin n++; tick(); end
        chk("timeout_trig_cycles", n, 16);
        chk("timeout_err", int'(o_err), 1);
        chk("timeout_trig_dropped", int'(o_search_trig_val), 0);
        i_en = 1'b0;
        tick();

        // Transfer on the expiry cycle wins; then SEARCH_WAIT times out.
        push(EV_SEARCH, 0, 0, 0);
        push(EV_ERR, 2, 0, 0);
        i_en = 1'b1;
        wait_sig(2, "trig_val", 8);
        repeat (15) tick();
        i_search_trig_rdy = 1'b1;
        tick();
        chk("expiry_xfer_state", int'(o_state), int'(SEARCH_WAIT));
        chk("expiry_xfer_no_err", int'(o_err), 0);
        wait_sig(4, "err", 40);
        i_en = 1'b0;
        repeat (3) tick();

        chk("sb_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
        $fatal(1, "bench time limit exceeded");
    end

endmodule

// File: doc/tuner_lock_seq.md
Name: tuner_lock_seq

Overview:
- Sequencer that sits above tuner_phy and drives its search and lock handshakes for one microring.
- Flow: triggers a sweep, captures the reported peaks, picks a target peak, programs tuner_phy's peak config and triggers lock.
- Services lock interrupts with bounded resume retries, then falls back to a full re-search.
- Gives a host one enable bit plus status, in place of hand-driving every handshake.

Parameters:
- DAC_WIDTH, 8, ring tune code width
- ADC_WIDTH, 8, power code width
- NUM_TARGET, 8, peak table depth
- MAX_RELOCK, 3, resume attempts per lock before a forced re-search
- MAX_SEARCH_RETRY, 2, consecutive zero-peak searches tolerated before FAIL
- TIMEOUT_CYCLES, 4096, watchdog limit in any wait state; counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_en  in  1  start/run request
- i_cfg_sel_mode  in  1  0 = max power, 1 = fixed index
- i_cfg_sel_idx  in  $clog2(NUM_TARGET)  peak index when mode = 1
- o_search_trig_val  out  1  search trigger valid
- i_search_trig_rdy  in  1  search trigger ready
- i_search_peaks_val  in  1  peak table valid
- o_search_peaks_rdy  out  1  peak table ready
- i_ring_tune_peaks  in  NUM_TARGET x DAC_WIDTH  peak tune codes
- i_pwr_peaks  in  NUM_TARGET x ADC_WIDTH  peak power codes
- i_peaks_cnt  in  $clog2(NUM_TARGET)+1  number of valid peaks
- o_lock_trig_val / i_lock_trig_rdy  out/in  1  lock trigger handshake
- i_lock_intr_val / o_lock_intr_rdy  in/out  1  lock-loss interrupt handshake
- o_lock_resume_val / i_lock_resume_rdy  out/in  1  resume handshake
- o_cfg_pwr_peak  out  ADC_WIDTH  to tuner_phy i_cfg_pwr_peak
- o_cfg_ring_tune_peak  out  DAC_WIDTH  to tuner_phy i_cfg_ring_tune_peak
- o_sel_idx  out  $clog2(NUM_TARGET)  selected peak index
- o_locked  out  1  high while in LOCKED
- o_err  out  1  high while in FAIL
- o_err_code  out  2  0 none, 1 no peaks, 2 timeout, 3 bad index
- o_relock_cnt  out  $clog2(MAX_RELOCK+1)  resumes used on the current lock
- o_state  out  tuner_seq_state_e  state monitor

Behaviour:
- Reset (async assert, sync deassert in the upstream synchronizer): state IDLE; all val/rdy outputs 0; cfg outputs 0; sel_idx 0; counters 0; o_locked 0; o_err 0; o_err_code 0.
- Handshakes: a transfer occurs in a cycle with val & rdy both high. A val, once raised, holds until that transfer. Never drop val without a transfer.
- All outputs are registered.
- IDLE: when i_en = 1, go to SEARCH_REQ next cycle.
- SEARCH_REQ: o_search_trig_val = 1. On transfer, go to SEARCH_WAIT.
- SEARCH_WAIT: o_search_peaks_rdy = 1. On transfer, latch all NUM_TARGET entries plus the count.
  - Count = 0: increment search_retry. If search_retry > MAX_SEARCH_RETRY, go to FAIL with code 1; otherwise go to SEARCH_REQ.
  - Count > 0: clear search_retry, go to SELECT.
- SELECT, max mode: scans one entry per cycle over indices 0..cnt-1 (cnt cycles). Strict greater-than compare, so ties keep the lowest index.
- SELECT, fixed mode: completes in 1 cycle. If idx >= cnt, go to FAIL with code 3.
- On SELECT completion: cfg outputs and o_sel_idx update in the same edge as the transition to LOCK_REQ. They hold stable until the next SELECT completion.
- LOCK_REQ: o_lock_trig_val = 1. On transfer, clear relock_cnt and go to LOCKED.
- LOCKED: o_locked = 1, o_lock_intr_rdy = 1. On interrupt transfer:
  - relock_cnt < MAX_RELOCK: increment it, go to RELOCK.
  - Otherwise: go to SEARCH_REQ (full re-search; search_retry restarts at 0).
- RELOCK: o_lock_resume_val = 1. On transfer, go to LOCKED.
- Watchdog: counts cycles in SEARCH_REQ, SEARCH_WAIT, LOCK_REQ and RELOCK. It clears on every state change. At TIMEOUT_CYCLES it forces FAIL with code 2 and drops any pending val; this is the sole exception to the hold-val rule. LOCKED has no timeout.
- FAIL: o_err = 1, all handshake outputs 0. Exits to IDLE only when i_en = 0, which also clears o_err_code. Error code and cfg outputs hold while in FAIL.
- i_en is sampled only in IDLE and FAIL. Deasserting it mid-sequence has no effect, because tuner_phy has no abort path.
- Simultaneous events: an interrupt and the watchdog cannot coincide (LOCKED is unwatched). A transfer in the same cycle the watchdog expires wins: the transfer is taken and the watchdog is cleared.
- Reset mid-operation: immediate return to IDLE. Peer handshakes are abandoned; tuner_phy is reset in the same domain.

Decomposition:
- tuner_phy_pkg gains typedef enum tuner_seq_state_e {IDLE, SEARCH_REQ, SEARCH_WAIT, SELECT, LOCK_REQ, LOCKED, RELOCK, FAIL}.
- tuner_phy_pkg gains tuner_seq_err_e for the error codes.
- One sub-module, tuner_peak_select: the sequential argmax/index scanner with start/done, chosen idx, power and tune outputs.

Test Plan:
- Peaks cnt=3, pwr {40,90,90}, mode 0 -> sel_idx=1, cfg_pwr_peak=90, cfg_ring_tune_peak=tune[1], lock_trig_val within 4 cycles of the peaks transfer.
- Mode 1, idx=5, cnt=3 -> FAIL, err_code=3; drop i_en -> IDLE, err_code=0.
- Three consecutive cnt=0 results (MAX_SEARCH_RETRY=2) -> exactly 3 search triggers, then FAIL, err_code=1.
- While locked, 4 interrupts (MAX_RELOCK=3) -> 3 resume transfers with relock_cnt 1,2,3, then a 4th causing search_trig_val with o_locked=0.
- Hold i_search_trig_rdy=0, TIMEOUT_CYCLES=16 -> trig_val high for 16 cycles, then FAIL, err_code=2, trig_val=0.
- Assert i_rst_n=0 while in RELOCK with resume_val held -> all outputs at reset values asynchronously; resume_val=0 before the next clock.
